// File: rtl/sd_cmd_phy.sv
// sd_cmd_phy: physical layer for the SD host CMD line.
//
// When strobe_in is accepted in IDLE, the block serialises {cmd_to_send, CRC7, 1'b1} MSB-first
// onto the CMD pin. It then releases the pin for TURN_CYC cycles and waits up to TIMEOUT cycles
// for a response start bit. A RESP_W-bit response frame is deserialised next. The result is
// held behind finish_ctp until the upper layer acks it.
//
// Optional feature macro: SD_CMD_PHY_CRC_EN
//   defined   - CRC7 is generated on TX and checked on RX.
//   undefined - the CRC field is sent as zero and crc_err flags only a bad end bit.
//
// Ports:
//   sd_clock, reset          clock (rising edge) and asynchronous active-high reset
//   strobe_in, no_response   start a transaction (IDLE only); skip the response phase
//   cmd_to_send              command word latched with strobe_in
//   ack_in                   acknowledges finish_ctp (DONE only)
//   idle_in                  synchronous abort back to IDLE
//   cmd_pin_in/out/oe        CMD pad input, output value and output enable
//   response                 last captured response frame
//   finish_ctp, busy         transaction complete / not idle
//   timeout_err, crc_err     no start bit seen / bad response CRC or end bit
module sd_cmd_phy #(
  parameter int unsigned CMD_W    = 40,
  parameter int unsigned RESP_W   = 48,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned TURN_CYC = 2
) (
  input  logic              sd_clock,
  input  logic              reset,
  input  logic              strobe_in,
  input  logic              ack_in,
  input  logic              idle_in,
  input  logic              no_response,
  input  logic [CMD_W-1:0]  cmd_to_send,
  input  logic              cmd_pin_in,
  output logic              cmd_pin_out,
  output logic              cmd_pin_oe,
  output logic [RESP_W-1:0] response,
  output logic              finish_ctp,
  output logic              timeout_err,
  output logic              crc_err,
  output logic              busy
);

  localparam int unsigned FrameW = CMD_W + 8;
  localparam int unsigned MaxA   = (FrameW > RESP_W) ? FrameW : RESP_W;
  localparam int unsigned MaxB   = (TIMEOUT > TURN_CYC) ? TIMEOUT : TURN_CYC;
  localparam int unsigned CntW   = $clog2(((MaxA > MaxB) ? MaxA : MaxB) + 1);

  typedef enum logic [2:0] {StIdle, StSend, StTurn, StWaitResp, StReceive, StDone} state_e;

  state_e              state_q, state_d;
  logic [FrameW-1:0]   sr_q, sr_d;
  logic [RESP_W-1:0]   rx_q, rx_d, resp_q, resp_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                no_resp_q, no_resp_d;
  logic                terr_q, terr_d, cerr_q, cerr_d;
  logic                out_q, out_d, oe_q, oe_d, fin_q, fin_d, busy_q, busy_d;

  logic [6:0]          tx_crc;
  logic [RESP_W-1:0]   rx_shift;
  logic                rx_bad;

  assign rx_shift = {rx_q[RESP_W-2:0], cmd_pin_in};

`ifdef SD_CMD_PHY_CRC_EN
  // R2 responses (136 bits) exclude their leading 8 bits from the CRC.
  localparam int unsigned RespCrcTop = (RESP_W == 136) ? 127 : RESP_W - 1;

  // Serial CRC7, x^7 + x^3 + 1, one message bit per step.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_cmd(input logic [CMD_W-1:0] w);
    logic [6:0] c;
    c = 7'd0;
    for (int i = CMD_W - 1; i >= 0; i--) c = crc7_step(c, w[i]);
    return c;
  endfunction

  function automatic logic [6:0] crc7_resp(input logic [RESP_W-1:0] f);
    logic [6:0] c;
    c = 7'd0;
    for (int i = RespCrcTop; i >= 8; i--) c = crc7_step(c, f[i]);
    return c;
  endfunction

  assign tx_crc = crc7_cmd(cmd_to_send);
  assign rx_bad = ~rx_shift[0] | (crc7_resp(rx_shift) != rx_shift[7:1]);
`else
  assign tx_crc = 7'd0;
  assign rx_bad = ~rx_shift[0];
`endif

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    rx_d      = rx_q;
    cnt_d     = cnt_q;
    no_resp_d = no_resp_q;
    resp_d    = resp_q;
    terr_d    = terr_q;
    cerr_d    = cerr_q;

    if (idle_in) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (strobe_in) begin
            state_d   = StSend;
            sr_d      = {cmd_to_send, tx_crc, 1'b1};
            no_resp_d = no_response;
            terr_d    = 1'b0;
            cerr_d    = 1'b0;
            cnt_d     = '0;
          end
        end
        StSend: begin
          sr_d = {sr_q[FrameW-2:0], 1'b1};
          if (cnt_q == CntW'(FrameW - 1)) begin
            cnt_d = '0;
            if (no_resp_q)          state_d = StDone;
            else if (TURN_CYC == 0) state_d = StWaitResp;
            else                    state_d = StTurn;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StTurn: begin
          if (cnt_q == CntW'(TURN_CYC - 1)) begin
            cnt_d   = '0;
            state_d = StWaitResp;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StWaitResp: begin
          // A start bit on the final count still wins over the timeout.
          if (!cmd_pin_in) begin
            rx_d    = rx_shift;
            cnt_d   = CntW'(1);
            state_d = StReceive;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            terr_d  = 1'b1;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StReceive: begin
          rx_d = rx_shift;
          if (cnt_q == CntW'(RESP_W - 1)) begin
            resp_d  = rx_shift;
            cerr_d  = rx_bad;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (ack_in) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    // Pad and handshake outputs are registered from the next state.
    oe_d   = (state_d == StSend);
    out_d  = oe_d ? sr_d[FrameW-1] : 1'b1;
    fin_d  = (state_d == StDone);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      rx_q      <= '0;
      cnt_q     <= '0;
      no_resp_q <= 1'b0;
      resp_q    <= '0;
      terr_q    <= 1'b0;
      cerr_q    <= 1'b0;
      out_q     <= 1'b1;
      oe_q      <= 1'b0;
      fin_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      rx_q      <= rx_d;
      cnt_q     <= cnt_d;
      no_resp_q <= no_resp_d;
      resp_q    <= resp_d;
      terr_q    <= terr_d;
      cerr_q    <= cerr_d;
      out_q     <= out_d;
      oe_q      <= oe_d;
      fin_q     <= fin_d;
      busy_q    <= busy_d;
    end
  end

  assign cmd_pin_out = out_q;
  assign cmd_pin_oe  = oe_q;
  assign response    = resp_q;
  assign finish_ctp  = fin_q;
  assign timeout_err = terr_q;
  assign crc_err     = cerr_q;
  assign busy        = busy_q;

endmodule
